// File: rtl/alu_issue_ctrl.sv
// Issue/retire controller for the 32-bit ALU: accepts MIPS R-type words, reads
// operands, drives the ALU for one cycle and hands the captured result to write-back.
module alu_issue_ctrl #(
  parameter int CNT_W  = 16,
  parameter int REG_AW = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              instr_valid,
  input  logic [31:0]       instr,
  output logic              instr_ready,
  output logic [REG_AW-1:0] rs_addr,
  output logic [REG_AW-1:0] rt_addr,
  input  logic [31:0]       rs_data,
  input  logic [31:0]       rt_data,
  output logic [31:0]       Src1,
  output logic [31:0]       Src2,
  output logic [4:0]        Shamt,
  output logic [5:0]        Funct1,
  input  logic [31:0]       Result,
  input  logic              Zero,
  input  logic              Carry,
  output logic              wb_valid,
  input  logic              wb_ready,
  output logic [REG_AW-1:0] wb_addr,
  output logic [31:0]       wb_data,
  output logic              wb_zero,
  output logic              wb_carry,
  output logic              illegal,
  output logic [CNT_W-1:0]  retired_cnt
);

  typedef enum logic [1:0] {IDLE, DECODE, EXEC, WB} state_t;

  state_t      state;
  state_t      state_next;
  logic [31:0] instr_q;
  logic [31:0] op1_q;
  logic [31:0] op2_q;
  logic [4:0]  shamt_q;
  logic [5:0]  funct_q;

  logic        legal;
  logic        is_sll;
  logic [5:0]  funct_map;
  logic        rd_zero;

  always_comb begin
    funct_map = '0;
    legal     = 1'b0;
    if (instr_q[31:26] == 6'h00) begin
      unique case (instr_q[5:0])
        6'h21:   begin funct_map = 6'h09; legal = 1'b1; end
        6'h23:   begin funct_map = 6'h0A; legal = 1'b1; end
        6'h24:   begin funct_map = 6'h11; legal = 1'b1; end
        6'h00:   begin funct_map = 6'h21; legal = 1'b1; end
        default: begin funct_map = '0;    legal = 1'b0; end
      endcase
    end
  end

  assign is_sll  = (instr_q[5:0] == 6'h00);
  assign rd_zero = (instr_q[15:11] == 5'd0);
  assign rs_addr = instr_q[25:21];
  assign rt_addr = instr_q[20:16];

  always_comb begin
    state_next  = state;
    instr_ready = 1'b0;
    wb_valid    = 1'b0;
    Src1        = '0;
    Src2        = '0;
    Shamt       = '0;
    Funct1      = '0;
    unique case (state)
      IDLE: begin
        instr_ready = 1'b1;
        if (instr_valid) state_next = DECODE;
      end
      DECODE: state_next = legal ? EXEC : IDLE;
      EXEC: begin
        Src1       = op1_q;
        Src2       = op2_q;
        Shamt      = shamt_q;
        Funct1     = funct_q;
        state_next = rd_zero ? IDLE : WB;
      end
      WB: begin
        wb_valid = 1'b1;
        if (wb_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      instr_q     <= '0;
      op1_q       <= '0;
      op2_q       <= '0;
      shamt_q     <= '0;
      funct_q     <= '0;
      wb_addr     <= '0;
      wb_data     <= '0;
      wb_zero     <= 1'b0;
      wb_carry    <= 1'b0;
      illegal     <= 1'b0;
      retired_cnt <= '0;
    end else begin
      state   <= state_next;
      illegal <= (state == DECODE) && !legal;
      if (state == IDLE && instr_valid) instr_q <= instr;
      // sll shifts rt, so rt is routed to Src1 and Src2 is forced to zero
      if (state == DECODE && legal) begin
        op1_q   <= is_sll ? rt_data : rs_data;
        op2_q   <= is_sll ? '0 : rt_data;
        shamt_q <= is_sll ? instr_q[10:6] : '0;
        funct_q <= funct_map;
      end
      if (state == EXEC) begin
        wb_addr  <= instr_q[15:11];
        wb_data  <= Result;
        wb_zero  <= Zero;
        wb_carry <= Carry;
        if (rd_zero) retired_cnt <= retired_cnt + CNT_W'(1);
      end
      if (state == WB && wb_ready) retired_cnt <= retired_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Bench for alu_issue_ctrl: ALU and register-file stubs, a transaction-level
// reference model compared every cycle, directed literal checks and random traffic.
module tb_alu_issue_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        instr_valid;
  logic [31:0] instr;
  logic        instr_ready;
  logic [4:0]  rs_addr, rt_addr;
  logic [31:0] rs_data, rt_data;
  logic [31:0] Src1, Src2;
  logic [4:0]  Shamt;
  logic [5:0]  Funct1;
  logic [31:0] Result;
  logic        Zero, Carry;
  logic        wb_valid, wb_ready;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic        wb_zero, wb_carry, illegal;
  logic [15:0] retired_cnt;

  logic [31:0] rf [32];
  int pass_cnt = 0;
  int total_cnt = 0;

  alu_issue_ctrl #(.CNT_W(16), .REG_AW(5)) dut (
    .clk(clk), .rst(rst), .instr_valid(instr_valid), .instr(instr),
    .instr_ready(instr_ready), .rs_addr(rs_addr), .rt_addr(rt_addr),
    .rs_data(rs_data), .rt_data(rt_data), .Src1(Src1), .Src2(Src2),
    .Shamt(Shamt), .Funct1(Funct1), .Result(Result), .Zero(Zero), .Carry(Carry),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_addr(wb_addr),
    .wb_data(wb_data), .wb_zero(wb_zero), .wb_carry(wb_carry),
    .illegal(illegal), .retired_cnt(retired_cnt)
  );

  always #5 clk = ~clk;

  assign rs_data = rf[rs_addr];
  assign rt_data = rf[rt_addr];

  // ALU stub: returns {zero, carry, result}
  function automatic logic [33:0] alu_fn(input logic [5:0] f, input logic [31:0] a,
                                         input logic [31:0] b, input logic [4:0] sh);
    logic [32:0] s;
    logic [31:0] r;
    logic        c;
    int          idx;
    r = 32'd0;
    c = 1'b0;
    case (f)
      6'h09: begin s = {1'b0, a} + {1'b0, b}; r = s[31:0]; c = s[32]; end
      6'h0A: begin r = a - b; c = (a < b); end
      6'h11: r = a & b;
      6'h21: begin
        r = a << sh;
        idx = 32 - int'(sh);
        c = (sh != 5'd0) ? a[idx] : 1'b0;
      end
      default: r = 32'd0;
    endcase
    return {(r == 32'd0), c, r};
  endfunction

  always_comb begin
    logic [33:0] o;
    o = alu_fn(Funct1, Src1, Src2, Shamt);
    Result = o[31:0];
    Carry  = o[32];
    Zero   = o[33];
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act !== exp)
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    else
      pass_cnt++;
  endtask

  // Reference model: tracks each transaction by cycles elapsed since acceptance.
  bit          m_on = 1'b0;
  bit          m_busy;
  int          m_age;
  logic [31:0] m_instr;
  logic [31:0] m_src1, m_src2;
  logic [4:0]  m_shamt;
  logic [5:0]  m_funct;
  logic [4:0]  m_wb_addr;
  logic [31:0] m_wb_data;
  logic        m_wb_zero, m_wb_carry, m_illegal;
  logic [15:0] m_cnt;

  function automatic logic [5:0] map_funct(input logic [31:0] w);
    if (w[31:26] != 6'h00) return 6'h00;
    case (w[5:0])
      6'h21:   return 6'h09;
      6'h23:   return 6'h0A;
      6'h24:   return 6'h11;
      6'h00:   return 6'h21;
      default: return 6'h00;
    endcase
  endfunction

  always @(posedge clk) begin
    logic [33:0] o;
    if (rst) begin
      m_on = 1'b1; m_busy = 1'b0; m_age = 0; m_instr = '0;
      m_src1 = '0; m_src2 = '0; m_shamt = '0; m_funct = '0;
      m_wb_addr = '0; m_wb_data = '0; m_wb_zero = 1'b0; m_wb_carry = 1'b0;
      m_illegal = 1'b0; m_cnt = '0;
    end else if (m_on) begin
      m_illegal = 1'b0;
      if (!m_busy) begin
        if (instr_valid) begin m_busy = 1'b1; m_age = 1; m_instr = instr; end
      end else if (m_age == 1) begin
        m_funct = map_funct(m_instr);
        if (m_funct == 6'h00) begin
          m_illegal = 1'b1; m_busy = 1'b0;
        end else begin
          if (m_funct == 6'h21) begin
            m_src1 = rf[m_instr[20:16]]; m_src2 = '0; m_shamt = m_instr[10:6];
          end else begin
            m_src1 = rf[m_instr[25:21]]; m_src2 = rf[m_instr[20:16]]; m_shamt = '0;
          end
          m_age = 2;
        end
      end else if (m_age == 2) begin
        o = alu_fn(m_funct, m_src1, m_src2, m_shamt);
        m_wb_data = o[31:0]; m_wb_carry = o[32]; m_wb_zero = o[33];
        m_wb_addr = m_instr[15:11];
        if (m_wb_addr == 5'd0) begin m_cnt++; m_busy = 1'b0; end
        else m_age = 3;
      end else if (wb_ready) begin
        m_cnt++; m_busy = 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    bit ex;
    if (m_on) begin
      ex = m_busy && m_age == 2;
      check("instr_ready", instr_ready, !m_busy);
      check("wb_valid", wb_valid, m_busy && m_age == 3);
      check("Src1", Src1, ex ? m_src1 : 32'd0);
      check("Src2", Src2, ex ? m_src2 : 32'd0);
      check("Shamt", Shamt, ex ? m_shamt : 5'd0);
      check("Funct1", Funct1, ex ? m_funct : 6'd0);
      check("wb_addr", wb_addr, m_wb_addr);
      check("wb_data", wb_data, m_wb_data);
      check("wb_zero", wb_zero, m_wb_zero);
      check("wb_carry", wb_carry, m_wb_carry);
      check("illegal", illegal, m_illegal);
      check("retired_cnt", retired_cnt, m_cnt);
      if (m_busy && m_age == 1) begin
        check("rs_addr", rs_addr, m_instr[25:21]);
        check("rt_addr", rt_addr, m_instr[20:16]);
      end
    end
  end

  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic issue(input logic [31:0] w);
    int n = 0;
    while (!instr_ready && n < 20) begin @(negedge clk); n++; end
    if (!instr_ready) check("issue_timeout", instr_ready, 1);
    instr = w; instr_valid = 1'b1;
    @(negedge clk);
    instr_valid = 1'b0;
  endtask

  function automatic logic [31:0] rand_instr();
    logic [31:0] w;
    int sel;
    w = $urandom;
    sel = $urandom_range(0, 7);
    if (sel < 6) begin
      w[31:26] = 6'h00;
      case ($urandom_range(0, 3))
        0: w[5:0] = 6'h21;
        1: w[5:0] = 6'h23;
        2: w[5:0] = 6'h24;
        default: w[5:0] = 6'h00;
      endcase
    end else if (sel == 6) begin
      w[31:26] = 6'h00;
    end
    if ($urandom_range(0, 5) == 0) w[15:11] = 5'd0;
    return w;
  endfunction

  initial begin
    for (int i = 0; i < 32; i++) rf[i] = 32'd0;
    rst = 1'b1; instr_valid = 1'b0; instr = '0; wb_ready = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rst_instr_ready", instr_ready, 1);
    check("rst_retired", retired_cnt, 0);
    check("rst_wb_data", wb_data, 0);

    // ADDU with carry-out and zero result
    rf[1] = 32'hFFFFFFFF; rf[2] = 32'h00000001;
    issue(32'h00221821);
    check("addu_rs_addr", rs_addr, 1);
    check("addu_rt_addr", rt_addr, 2);
    @(negedge clk);
    check("addu_funct1", Funct1, 6'h09);
    @(negedge clk);
    check("addu_wb_valid", wb_valid, 1);
    check("addu_wb_addr", wb_addr, 3);
    check("addu_wb_data", wb_data, 0);
    check("addu_wb_zero", wb_zero, 1);
    check("addu_wb_carry", wb_carry, 1);
    @(negedge clk);
    check("addu_retired", retired_cnt, 1);

    // SUBU with borrow
    rf[1] = 32'd5; rf[2] = 32'd7;
    issue(32'h00221823);
    @(negedge clk);
    check("subu_funct1", Funct1, 6'h0A);
    @(negedge clk);
    check("subu_wb_data", wb_data, 32'hFFFFFFFE);
    check("subu_wb_carry", wb_carry, 1);
    check("subu_wb_zero", wb_zero, 0);

    // SLL followed immediately by AND
    do_reset();
    rf[2] = 32'h10000001;
    issue(32'h00022100);
    @(negedge clk);
    check("sll_src1", Src1, 32'h10000001);
    check("sll_src2", Src2, 0);
    check("sll_shamt", Shamt, 4);
    check("sll_funct1", Funct1, 6'h21);
    @(negedge clk);
    check("sll_wb_addr", wb_addr, 4);
    check("sll_wb_data", wb_data, 32'h00000010);
    check("sll_wb_carry", wb_carry, 1);
    rf[1] = 32'hF0F0F0F0; rf[2] = 32'hFF00FF00;
    issue(32'h00221824);
    @(negedge clk);
    @(negedge clk);
    check("and_wb_data", wb_data, 32'hF000F000);
    @(negedge clk);
    check("pair_retired", retired_cnt, 2);

    // Illegal opcode: one-cycle pulse, not counted
    issue(32'h20220005);
    @(negedge clk);
    check("ill_pulse", illegal, 1);
    check("ill_ready", instr_ready, 1);
    check("ill_wb_valid", wb_valid, 0);
    @(negedge clk);
    check("ill_pulse_end", illegal, 0);
    check("ill_retired", retired_cnt, 2);

    // rd == 0: retired without write-back
    issue(32'h00220021);
    @(negedge clk);
    @(negedge clk);
    check("rd0_ready", instr_ready, 1);
    check("rd0_wb_valid", wb_valid, 0);
    check("rd0_retired", retired_cnt, 3);

    // Write-back backpressure
    wb_ready = 1'b0;
    rf[1] = 32'h100; rf[2] = 32'h23;
    issue(32'h00221821);
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("bp_wb_valid", wb_valid, 1);
      check("bp_wb_data", wb_data, 32'h123);
      check("bp_ready", instr_ready, 0);
    end
    @(negedge clk);
    check("bp_wb_valid4", wb_valid, 1);
    wb_ready = 1'b1;
    @(negedge clk);
    check("bp_idle", instr_ready, 1);
    check("bp_retired", retired_cnt, 4);

    // Reset while in EXEC
    issue(32'h00221821);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rexec_ready", instr_ready, 1);
    check("rexec_wb_valid", wb_valid, 0);
    check("rexec_funct1", Funct1, 0);
    check("rexec_src1", Src1, 0);
    check("rexec_retired", retired_cnt, 0);
    check("rexec_wb_data", wb_data, 0);
    @(negedge clk);
    check("rexec_no_wb", wb_valid, 0);

    // Random traffic with backpressure and occasional reset
    for (int c = 0; c < 3000; c++) begin
      instr_valid = ($urandom_range(0, 2) != 0);
      instr = rand_instr();
      wb_ready = ($urandom_range(0, 2) != 0);
      rst = ($urandom_range(0, 299) == 0);
      rf[$urandom_range(0, 31)] = $urandom;
      @(negedge clk);
    end
    rst = 1'b0; instr_valid = 1'b0;
    @(negedge clk);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
